// File: rtl/audio_pkg.sv
// Shared definitions for the audio-path blocks: mode codes, FSM encoding and
// the saturating adder used by the mix datapaths.
package audio_pkg;

  localparam logic [1:0] MODE_BYPASS   = 2'b00;
  localparam logic [1:0] MODE_DELAY    = 2'b01;
  localparam logic [1:0] MODE_ECHO     = 2'b10;
  localparam logic [1:0] MODE_FEEDBACK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MIX   = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  // Adds two sign-extended operands one bit wider than w and clamps the result
  // to the signed w-bit range; callers truncate the return value to w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi)      return hi[31:0];
    else if (sum < lo) return lo[31:0];
    else               return sum[31:0];
  endfunction

endpackage

// File: rtl/time_mod_ram.sv
// Single-port synchronous sample buffer with registered, read-first output.
// No reset on storage or read register so it maps onto block RAM.
module time_mod_ram #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (re) rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/time_mod_delay.sv
// Delay / echo processor over a circular sample buffer: one signed sample in
// per accepted ready strobe, one processed sample out four clocks later.
module time_mod_delay
  import audio_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int ADDR_W     = 12,
  parameter int ATTN_SHIFT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic [7:0]              controls,
  output logic signed [WIDTH-1:0] audio_out,
  output logic                    out_valid,
  output logic                    busy,
  output state_t                  dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: ready is a one-cycle strobe accepted only while busy is low
  // (state IDLE); strobes seen while busy are dropped, never queued. Each
  // accepted strobe yields exactly one out_valid pulse unless reset intervenes.

  state_t                  state, state_nx;
  logic signed [WIDTH-1:0] in_q;
  logic [7:0]              ctrl_q;
  logic signed [WIDTH-1:0] out_q;
  logic signed [WIDTH-1:0] wr_q;
  logic [ADDR_W-1:0]       wp;
  logic [ADDR_W:0]         fill;
  logic [ADDR_W:0]         dlen;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_we;
  logic                    ram_re;
  logic [WIDTH-1:0]        ram_rdata;
  logic signed [WIDTH-1:0] d;
  logic signed [WIDTH-1:0] e;
  logic signed [WIDTH-1:0] sum;

  // D = (c+1) << (ADDR_W-6); when D == DEPTH the low bits vanish and rd_addr == wp.
  assign dlen    = ({{(ADDR_W-5){1'b0}}, ctrl_q[5:0]} + (ADDR_W+1)'(1)) << (ADDR_W - 6);
  assign rd_addr = wp - dlen[ADDR_W-1:0];

  assign d   = (fill < dlen) ? '0 : $signed(ram_rdata);
  assign e   = d >>> ATTN_SHIFT;
  assign sum = WIDTH'(sat_add(32'(in_q), 32'(e), WIDTH));

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  time_mod_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx = state;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = wp;
    case (state)
      ST_IDLE:  if (ready) state_nx = ST_READ;
      ST_READ: begin
        ram_re   = 1'b1;
        ram_addr = rd_addr;
        state_nx = ST_MIX;
      end
      ST_MIX:   state_nx = ST_WRITE;
      ST_WRITE: begin
        ram_we   = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      in_q      <= '0;
      ctrl_q    <= '0;
      out_q     <= '0;
      wr_q      <= '0;
      wp        <= '0;
      fill      <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ready) begin
            in_q   <= audio_in;
            ctrl_q <= controls;
          end
        end
        ST_MIX: begin
          case (ctrl_q[7:6])
            MODE_BYPASS:   begin out_q <= in_q; wr_q <= in_q; end
            MODE_DELAY:    begin out_q <= d;    wr_q <= in_q; end
            MODE_ECHO:     begin out_q <= sum;  wr_q <= in_q; end
            MODE_FEEDBACK: begin out_q <= sum;  wr_q <= sum;  end
            default:       begin out_q <= in_q; wr_q <= in_q; end
          endcase
        end
        ST_WRITE: begin
          audio_out <= out_q;
          out_valid <= 1'b1;
          wp        <= wp + ADDR_W'(1);
          if (fill != (ADDR_W+1)'(DEPTH)) fill <= fill + (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_mod_delay.sv
// Directed and randomized bench for time_mod_delay at WIDTH=18, ADDR_W=6
// (so D = c+1), with a history-queue reference model of the delay line.
module tb_time_mod_delay;

  logic        clock;
  logic        reset;
  logic        ready;
  logic [17:0] audio_in;
  logic [7:0]  controls;
  logic [17:0] audio_out;
  logic        out_valid;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Values written to the buffer, oldest first, at most DEPTH=64 kept.
  int hist[$];

  time_mod_delay #(
    .WIDTH      (18),
    .ADDR_W     (6),
    .ATTN_SHIFT (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .audio_in  (audio_in),
    .controls  (controls),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp18(input int v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  // Reference: delayed sample is the value written D samples ago, or 0 if
  // fewer than D samples have been written since reset.
  function automatic logic [17:0] model_step(input logic [17:0] s, input logic [7:0] c);
    logic signed [17:0] ss;
    int dl, sv, dv, ev, mix, outv, wrv;
    ss = s;
    sv = ss;
    dl = int'(c[5:0]) + 1;
    dv = (hist.size() >= dl) ? hist[hist.size() - dl] : 0;
    ev = dv >>> 1;
    mix = clamp18(sv + ev);
    case (c[7:6])
      2'b00:   begin outv = sv;  wrv = sv;  end
      2'b01:   begin outv = dv;  wrv = sv;  end
      2'b10:   begin outv = mix; wrv = sv;  end
      default: begin outv = mix; wrv = mix; end
    endcase
    hist.push_back(wrv);
    if (hist.size() > 64) void'(hist.pop_front());
    return outv[17:0];
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    hist.delete();
  endtask

  // One accepted sample; optionally a second strobe one cycle later that must be dropped.
  task automatic run_sample(input string tag, input logic [17:0] s, input logic [7:0] c,
                            input bit dup, input logic [17:0] exp);
    @(negedge clock);
    ready    = 1'b1;
    audio_in = s;
    controls = c;
    @(negedge clock);
    ready    = dup;
    audio_in = ~s;
    controls = c ^ 8'hC0;
    chk({tag, "_busy1"}, {30'd0, busy, out_valid}, 32'b10);
    @(negedge clock);
    ready = 1'b0;
    chk({tag, "_busy2"}, {30'd0, busy, out_valid}, 32'b10);
    @(negedge clock);
    chk({tag, "_busy3"}, {30'd0, busy, out_valid}, 32'b10);
    @(negedge clock);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out"}, {14'd0, audio_out}, {14'd0, exp});
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  int pulses;
  logic [17:0] e_out;
  logic [17:0] rs;
  logic [7:0]  rc;
  int fb_exp[6] = '{1000, 500, 250, 125, 62, 31};

  initial begin
    reset    = 1'b0;
    ready    = 1'b0;
    audio_in = '0;
    controls = '0;

    // Reset state, with a ready pulse while reset is held.
    repeat (2) @(negedge clock);
    ready    = 1'b1;
    audio_in = 18'h00777;
    @(negedge clock);
    ready = 1'b0;
    chk("rst_out", {14'd0, audio_out}, 32'd0);
    chk("rst_ctl", {29'd0, busy, out_valid, 1'b0}, 32'd0);
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    chk("rst_nopulse", pulses, 0);
    chk("rst_idle", {31'd0, busy}, 32'd0);

    // Bypass, with a dropped second strobe.
    void'(model_step(18'h01234, 8'h00));
    run_sample("bypass", 18'h01234, 8'h00, 1'b1, 18'h01234);

    // Pure delay, D=3.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      void'(model_step(18'(i), 8'h42));
      run_sample("delay", 18'(i), 8'h42, 1'b0, (i <= 3) ? 18'd0 : 18'(i - 3));
    end

    // Echo saturation, positive then negative rails.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      void'(model_step(18'h1FFFF, 8'h80));
      run_sample("echo_pos", 18'h1FFFF, 8'h80, 1'b0, 18'h1FFFF);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      void'(model_step(18'h20000, 8'h80));
      run_sample("echo_neg", 18'h20000, 8'h80, 1'b0, 18'h20000);
    end

    // Feedback impulse decay.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rs = (i == 0) ? 18'd1000 : 18'd0;
      void'(model_step(rs, 8'hC0));
      run_sample("feedback", rs, 8'hC0, 1'b0, 18'(fb_exp[i]));
    end

    // Full-depth delay across pointer wrap.
    do_reset();
    for (int i = 0; i < 130; i++) begin
      void'(model_step(18'(i), 8'h7F));
      run_sample("wrap", 18'(i), 8'h7F, 1'b0, (i < 64) ? 18'd0 : 18'(i - 64));
    end

    // Reset during MIX aborts the sample and clears fill.
    @(negedge clock);
    ready    = 1'b1;
    audio_in = 18'd77;
    controls = 8'h40;
    @(negedge clock);
    ready = 1'b0;
    @(negedge clock);
    chk("abort_inmix", {30'd0, dbg_state}, 32'd2);
    reset  = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    reset = 1'b1;
    hist.delete();
    repeat (3) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    chk("abort_nopulse", pulses, 0);
    void'(model_step(18'd5, 8'h40));
    run_sample("abort_next", 18'd5, 8'h40, 1'b0, 18'd0);
    void'(model_step(18'd6, 8'h40));
    run_sample("abort_next2", 18'd6, 8'h40, 1'b0, 18'd5);

    // Randomized modes, delays and samples against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rs = 18'($urandom_range(0, 262143));
      if ($urandom_range(0, 3) == 0) rc = 8'($urandom_range(0, 255));
      else rc = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
      e_out = model_step(rs, rc);
      run_sample("rand", rs, rc, 1'($urandom_range(0, 1)), e_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
